// File: rtl/game_round_ctrl_pkg.sv
// Shared types and widths for the guessing-game round controller.
// Holds the FSM state encoding and the rule for avoiding repeated targets.
package game_round_ctrl_pkg;

    localparam int NUM_W   = 4;
    localparam int LIVES_W = 2;
    localparam int TIMER_W = 26;

    localparam logic [NUM_W-1:0] SCORE_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAW  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_PLAY  = 3'd3,
        ST_CHECK = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

    // A drawn number equal to the previous target is bumped by one (wrapping).
    function automatic logic [NUM_W-1:0] next_target(
        input logic [NUM_W-1:0] drawn,
        input logic [NUM_W-1:0] last
    );
        return (drawn != last) ? drawn : drawn + NUM_W'(1);
    endfunction

endpackage

// File: rtl/game_round_ctrl_round_timer.sv
// Per-guess countdown: reloads to ROUND_TICKS-1, counts down while ticking, holds at zero.
// Zero flag is combinational from the count register.
module round_timer
    import game_round_ctrl_pkg::*;
#(
    parameter int ROUND_TICKS = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic tick_i,
    output logic zero_o
);

    localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(ROUND_TICKS - 1);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = RELOAD;
        end else if (tick_i && (count_q != '0)) begin
            count_d = count_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/game_round_ctrl.sv
// Round controller for a number-guessing game: draws targets, times guesses, scores hits and misses.
// Result one cycle after submit; next target valid three cycles after CHECK.
module game_round_ctrl
    import game_round_ctrl_pkg::*;
#(
    parameter int ROUND_TICKS = 50_000_000,
    parameter int START_LIVES = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               submit,
    input  logic [NUM_W-1:0]   guess,
    input  logic [NUM_W-1:0]   gen_result,
    output logic               gen_enable,
    output logic [NUM_W-1:0]   target,
    output logic               target_valid,
    output logic [NUM_W-1:0]   score,
    output logic [LIVES_W-1:0] lives,
    output logic               hit,
    output logic               miss,
    output logic               game_over
);

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);

    state_t             state_q,       state_d;
    logic [NUM_W-1:0]   target_q,      target_d;
    logic [NUM_W-1:0]   last_target_q, last_target_d;
    logic [NUM_W-1:0]   score_q,       score_d;
    logic [LIVES_W-1:0] lives_q,       lives_d;
    logic [NUM_W-1:0]   guess_q,       guess_d;
    logic               timeout_q,     timeout_d;

    logic timer_zero;
    logic match;

    round_timer #(
        .ROUND_TICKS (ROUND_TICKS)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (state_q == ST_LOAD),
        .tick_i (state_q == ST_PLAY),
        .zero_o (timer_zero)
    );

    // A timeout is scored as a mismatch regardless of the stale latched guess.
    assign match = !timeout_q && (guess_q == target_q);

    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        last_target_d = last_target_q;
        score_d       = score_q;
        lives_d       = lives_q;
        guess_d       = guess_q;
        timeout_d     = timeout_q;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d = ST_DRAW;
                    score_d = '0;
                    lives_d = LIVES_INIT;
                end
            end
            ST_DRAW: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                target_d      = next_target(gen_result, last_target_q);
                last_target_d = target_d;
                state_d       = ST_PLAY;
            end
            ST_PLAY: begin
                if (submit) begin
                    guess_d   = guess;
                    timeout_d = 1'b0;
                    state_d   = ST_CHECK;
                end else if (timer_zero) begin
                    timeout_d = 1'b1;
                    state_d   = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (match) begin
                    score_d = (score_q == SCORE_MAX) ? SCORE_MAX : score_q + NUM_W'(1);
                    state_d = (score_d == SCORE_MAX) ? ST_OVER : ST_DRAW;
                end else begin
                    lives_d = (lives_q == '0) ? '0 : lives_q - LIVES_W'(1);
                    state_d = (lives_d == '0) ? ST_OVER : ST_DRAW;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            target_q      <= '0;
            last_target_q <= '0;
            score_q       <= '0;
            lives_q       <= '0;
            guess_q       <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            last_target_q <= last_target_d;
            score_q       <= score_d;
            lives_q       <= lives_d;
            guess_q       <= guess_d;
            timeout_q     <= timeout_d;
        end
    end

    // Outputs are forced quiet during reset so stale state never leaks out.
    assign gen_enable   = !rst && (state_q == ST_DRAW);
    assign target_valid = !rst && (state_q == ST_PLAY);
    assign game_over    = !rst && (state_q == ST_OVER);
    assign hit          = !rst && (state_q == ST_CHECK) && match;
    assign miss         = !rst && (state_q == ST_CHECK) && !match;
    assign target       = rst ? '0 : target_q;
    assign score        = rst ? '0 : score_q;
    assign lives        = rst ? '0 : lives_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl with a short round timer.
module tb_game_round_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       submit;
    logic [3:0] guess;
    logic [3:0] gen_result;
    logic       gen_enable;
    logic [3:0] target;
    logic       target_valid;
    logic [3:0] score;
    logic [1:0] lives;
    logic       hit;
    logic       miss;
    logic       game_over;

    game_round_ctrl #(
        .ROUND_TICKS (4),
        .START_LIVES (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .submit       (submit),
        .guess        (guess),
        .gen_result   (gen_result),
        .gen_enable   (gen_enable),
        .target       (target),
        .target_valid (target_valid),
        .score        (score),
        .lives        (lives),
        .hit          (hit),
        .miss         (miss),
        .game_over    (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {gen_enable, target_valid, target, score, lives, hit, miss, game_over}
    logic [14:0] act;
    assign act = {gen_enable, target_valid, target, score, lives, hit, miss, game_over};

    typedef struct packed {
        logic        start;
        logic        submit;
        logic [3:0]  guess;
        logic [3:0]  gen;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl [20];

    int errors = 0;
    int checks = 0;

    logic [3:0] m_score;
    logic [1:0] m_lives;
    logic [3:0] m_last;

    function automatic logic [14:0] ob(input logic ge, input logic tv, input logic [3:0] t,
                                       input logic [3:0] s, input logic [1:0] l,
                                       input logic h, input logic m, input logic go);
        return {ge, tv, t, s, l, h, m, go};
    endfunction

    function automatic vec_t mk(input logic st, input logic sb, input logic [3:0] gs,
                                input logic [3:0] gn, input logic [14:0] e);
        vec_t v;
        v.start  = st;
        v.submit = sb;
        v.guess  = gs;
        v.gen    = gn;
        v.exp    = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [14:0] a, input logic [14:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got ge/tv/tgt/score/lives/hit/miss/over=%b expected %b", nm, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered with the DUT in DRAW. idle>=4 lets the round time out; idle==3 lands
    // the submit on the cycle the timer reaches zero.
    task automatic do_round(input logic [3:0] g, input logic [3:0] gs, input int idle,
                            input logic auto_hit);
        logic [3:0] t;
        logic [3:0] gv;
        logic       h;
        logic       over;
        t = (g != m_last) ? g : g + 4'd1;
        gen_result = g;
        step();
        chk("round_load", act, ob(1'b0, 1'b0, m_last, m_score, m_lives, 1'b0, 1'b0, 1'b0));
        step();
        chk("round_play", act, ob(1'b0, 1'b1, t, m_score, m_lives, 1'b0, 1'b0, 1'b0));
        m_last = t;
        gv = auto_hit ? t : gs;
        if (idle >= 4) begin
            for (int k = 0; k < 3; k++) begin
                step();
                chk("round_wait", act, ob(1'b0, 1'b1, t, m_score, m_lives, 1'b0, 1'b0, 1'b0));
            end
            step();
            h = 1'b0;
        end else begin
            for (int k = 0; k < idle; k++) begin
                step();
                chk("round_wait", act, ob(1'b0, 1'b1, t, m_score, m_lives, 1'b0, 1'b0, 1'b0));
            end
            submit = 1'b1;
            guess  = gv;
            step();
            submit = 1'b0;
            h = (gv == t);
        end
        chk("round_check", act, ob(1'b0, 1'b0, t, m_score, m_lives, h, !h, 1'b0));
        if (h) m_score = (m_score == 4'd15) ? 4'd15 : m_score + 4'd1;
        else   m_lives = m_lives - 2'd1;
        over = (h && (m_score == 4'd15)) || (!h && (m_lives == 2'd0));
        step();
        chk("round_next", act, ob(!over, 1'b0, t, m_score, m_lives, 1'b0, 1'b0, over));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mk(1'b1, 1'b0, 4'd0,  4'd5,  ob(1'b1, 1'b0, 4'd0,  4'd0, 2'd3, 1'b0, 1'b0, 1'b0));
        tbl[1]  = mk(1'b0, 1'b0, 4'd0,  4'd5,  ob(1'b0, 1'b0, 4'd0,  4'd0, 2'd3, 1'b0, 1'b0, 1'b0));
        tbl[2]  = mk(1'b0, 1'b0, 4'd0,  4'd5,  ob(1'b0, 1'b1, 4'd5,  4'd0, 2'd3, 1'b0, 1'b0, 1'b0));
        tbl[3]  = mk(1'b0, 1'b1, 4'd5,  4'd5,  ob(1'b0, 1'b0, 4'd5,  4'd0, 2'd3, 1'b1, 1'b0, 1'b0));
        tbl[4]  = mk(1'b0, 1'b0, 4'd0,  4'd9,  ob(1'b1, 1'b0, 4'd5,  4'd1, 2'd3, 1'b0, 1'b0, 1'b0));
        tbl[5]  = mk(1'b0, 1'b1, 4'd5,  4'd9,  ob(1'b0, 1'b0, 4'd5,  4'd1, 2'd3, 1'b0, 1'b0, 1'b0));
        tbl[6]  = mk(1'b0, 1'b0, 4'd0,  4'd9,  ob(1'b0, 1'b1, 4'd9,  4'd1, 2'd3, 1'b0, 1'b0, 1'b0));
        tbl[7]  = mk(1'b0, 1'b1, 4'd3,  4'd9,  ob(1'b0, 1'b0, 4'd9,  4'd1, 2'd3, 1'b0, 1'b1, 1'b0));
        tbl[8]  = mk(1'b0, 1'b0, 4'd0,  4'd9,  ob(1'b1, 1'b0, 4'd9,  4'd1, 2'd2, 1'b0, 1'b0, 1'b0));
        tbl[9]  = mk(1'b0, 1'b0, 4'd0,  4'd9,  ob(1'b0, 1'b0, 4'd9,  4'd1, 2'd2, 1'b0, 1'b0, 1'b0));
        tbl[10] = mk(1'b0, 1'b0, 4'd0,  4'd9,  ob(1'b0, 1'b1, 4'd10, 4'd1, 2'd2, 1'b0, 1'b0, 1'b0));
        tbl[11] = mk(1'b1, 1'b0, 4'd0,  4'd9,  ob(1'b0, 1'b1, 4'd10, 4'd1, 2'd2, 1'b0, 1'b0, 1'b0));
        tbl[12] = mk(1'b0, 1'b1, 4'd10, 4'd9,  ob(1'b0, 1'b0, 4'd10, 4'd1, 2'd2, 1'b1, 1'b0, 1'b0));
        tbl[13] = mk(1'b0, 1'b0, 4'd0,  4'd15, ob(1'b1, 1'b0, 4'd10, 4'd2, 2'd2, 1'b0, 1'b0, 1'b0));
        tbl[14] = mk(1'b0, 1'b0, 4'd0,  4'd15, ob(1'b0, 1'b0, 4'd10, 4'd2, 2'd2, 1'b0, 1'b0, 1'b0));
        tbl[15] = mk(1'b0, 1'b0, 4'd0,  4'd15, ob(1'b0, 1'b1, 4'd15, 4'd2, 2'd2, 1'b0, 1'b0, 1'b0));
        tbl[16] = mk(1'b0, 1'b1, 4'd15, 4'd15, ob(1'b0, 1'b0, 4'd15, 4'd2, 2'd2, 1'b1, 1'b0, 1'b0));
        tbl[17] = mk(1'b1, 1'b0, 4'd0,  4'd15, ob(1'b1, 1'b0, 4'd15, 4'd3, 2'd2, 1'b0, 1'b0, 1'b0));
        tbl[18] = mk(1'b0, 1'b0, 4'd0,  4'd15, ob(1'b0, 1'b0, 4'd15, 4'd3, 2'd2, 1'b0, 1'b0, 1'b0));
        tbl[19] = mk(1'b0, 1'b0, 4'd0,  4'd15, ob(1'b0, 1'b1, 4'd0,  4'd3, 2'd2, 1'b0, 1'b0, 1'b0));

        rst = 1'b1; start = 1'b0; submit = 1'b0; guess = 4'd0; gen_result = 4'd0;
        #1;
        chk("reset_during", act, 15'd0);
        step();
        step();
        chk("reset_held", act, 15'd0);
        rst = 1'b0;
        step();
        chk("reset_after", act, 15'd0);

        for (int i = 0; i < 20; i++) begin
            start      = tbl[i].start;
            submit     = tbl[i].submit;
            guess      = tbl[i].guess;
            gen_result = tbl[i].gen;
            step();
            chk($sformatf("vec%0d", i), act, tbl[i].exp);
        end
        start = 1'b0; submit = 1'b0;
        m_score = 4'd3; m_lives = 2'd2; m_last = 4'd0;

        // Timeout from the table's last PLAY entry: miss on the fourth cycle.
        for (int k = 0; k < 3; k++) begin
            step();
            chk("to_wait", act, ob(1'b0, 1'b1, 4'd0, 4'd3, 2'd2, 1'b0, 1'b0, 1'b0));
        end
        step();
        chk("to_miss", act, ob(1'b0, 1'b0, 4'd0, 4'd3, 2'd2, 1'b0, 1'b1, 1'b0));
        step();
        chk("to_draw", act, ob(1'b1, 1'b0, 4'd0, 4'd3, 2'd1, 1'b0, 1'b0, 1'b0));
        m_lives = 2'd1;

        do_round(4'd7, 4'd0, 3, 1'b1);
        do_round(4'd2, 4'd5, 0, 1'b0);

        submit = 1'b1; guess = 4'd2;
        step();
        submit = 1'b0;
        chk("over_submit_ignored", act, ob(1'b0, 1'b0, 4'd2, 4'd4, 2'd0, 1'b0, 1'b0, 1'b1));
        start = 1'b1;
        step();
        start = 1'b0;
        chk("over_restart", act, ob(1'b1, 1'b0, 4'd2, 4'd0, 2'd3, 1'b0, 1'b0, 1'b0));
        m_score = 4'd0; m_lives = 2'd3;

        do_round(4'd4, 4'd0, 0, 1'b0);
        do_round(4'd4, 4'd0, 1, 1'b0);
        do_round(4'd4, 4'd0, 4, 1'b0);
        submit = 1'b1; guess = m_last;
        step();
        submit = 1'b0;
        chk("three_miss_over", act, ob(1'b0, 1'b0, m_last, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1));
        start = 1'b1;
        step();
        start = 1'b0;
        chk("three_miss_restart", act, ob(1'b1, 1'b0, m_last, 4'd0, 2'd3, 1'b0, 1'b0, 1'b0));
        m_score = 4'd0; m_lives = 2'd3;

        for (int i = 0; i < 15; i++) begin
            logic [3:0] gi;
            gi = 4'(i);
            do_round(gi, 4'd0, i % 3, 1'b1);
        end
        step();
        chk("sat_hold", act, ob(1'b0, 1'b0, m_last, 4'd15, 2'd3, 1'b0, 1'b0, 1'b1));

        start = 1'b1;
        step();
        start = 1'b0;
        chk("sat_restart", act, ob(1'b1, 1'b0, m_last, 4'd0, 2'd3, 1'b0, 1'b0, 1'b0));
        gen_result = 4'd3;
        step();
        step();
        step();
        chk("mid_play", act, ob(1'b0, 1'b1, 4'd3, 4'd0, 2'd3, 1'b0, 1'b0, 1'b0));
        rst = 1'b1;
        #1;
        chk("mid_rst_during", act, 15'd0);
        step();
        chk("mid_rst_edge", act, 15'd0);
        rst = 1'b0;
        step();
        chk("mid_rst_after", act, 15'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("clean_start", act, ob(1'b1, 1'b0, 4'd0, 4'd0, 2'd3, 1'b0, 1'b0, 1'b0));
        m_score = 4'd0; m_lives = 2'd3; m_last = 4'd0;
        do_round(4'd0, 4'd0, 4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_round_ctrl.md
GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 Parameter ROUND_TICKS, default 50_000_000, SHALL set the clk cycles allowed per guess; legal range is 2..2^26-1.
REQ-002 Parameter START_LIVES, default 3, SHALL set the lives loaded at game start; legal range is 1..3.
REQ-003 Port clk, input, 1 bit: the single system clock; all logic is on posedge clk.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port start, input, 1 bit: single-cycle pulse that begins a game; honoured only in IDLE or OVER.
REQ-006 Port submit, input, 1 bit: single-cycle pulse that registers the player's guess; honoured only in PLAY.
REQ-007 Port guess, input, 4 bits: the player's switch value, sampled in the cycle submit is seen.
REQ-008 Port gen_result, input, 4 bits: registered output of the number generator.
REQ-009 Port gen_enable, output, 1 bit: enable to the number generator; high for exactly one cycle per draw.
REQ-010 Port target, output, 4 bits: the current number to guess.
REQ-011 Port target_valid, output, 1 bit: high while in PLAY.
REQ-012 Port score, output, 4 bits: the count of correct guesses, saturating at 15.
REQ-013 Port lives, output, 2 bits: lives remaining.
REQ-014 Port hit, output, 1 bit: one-cycle pulse on a correct guess.
REQ-015 Port miss, output, 1 bit: one-cycle pulse on a wrong guess or a timeout.
REQ-016 Port game_over, output, 1 bit: high while in OVER.

Function
REQ-017 The FSM SHALL have the states IDLE, DRAW, LOAD, PLAY, CHECK and OVER, encoded in a shared enum.
REQ-018 IDLE -> DRAW on start; on that transition score SHALL be set to 0 and lives to START_LIVES.
REQ-019 DRAW: gen_enable is 1 for this single cycle; the next state is always LOAD.
REQ-020 LOAD: gen_result is sampled one cycle after gen_enable.
- If gen_result != last_target, target = gen_result.
- Otherwise target = (gen_result + 1) mod 16.
- last_target is updated to the new target.
- The next state is PLAY.
REQ-021 On entry to PLAY, the timer SHALL load ROUND_TICKS-1 and decrement once per cycle.
REQ-022 In PLAY, submit SHALL latch guess and go to CHECK.
REQ-023 In PLAY, if the timer is 0 with no submit, the FSM SHALL go to CHECK with a forced mismatch.
REQ-024 If submit and timer==0 occur in the same cycle, submit SHALL win and guess SHALL be compared normally.
REQ-025 CHECK on a match:
- hit pulses.
- score increments, saturating at 15.
- If the new score is 15, go to OVER; else go to DRAW.
REQ-026 CHECK on a mismatch:
- miss pulses.
- lives decrements.
- If the new lives is 0, go to OVER; else go to DRAW.
REQ-027 OVER: score and lives SHALL hold; start SHALL behave as in REQ-018.
REQ-028 start outside IDLE/OVER and submit outside PLAY SHALL be ignored, with no state or output change.
REQ-029 Latency: from submit in PLAY to hit/miss SHALL be 1 cycle; from CHECK to the next target_valid SHALL be 3 cycles (DRAW, LOAD, PLAY).
REQ-030 Every consecutive pair of targets within a game SHALL differ.

Reset
REQ-031 rst SHALL dominate all inputs and may be asserted in any state, mid-round included.
REQ-032 While rst=1 and on the cycle after it, the following SHALL hold:
- state = IDLE.
- target = 0, last_target = 0, score = 0, lives = 0.
- timer = 0.
- gen_enable, target_valid, hit, miss and game_over all 0.

Structure
REQ-033 A shared package SHALL hold the state enum, the 4-bit number width constant and the lives width constant.
REQ-034 The round timer SHALL be one sub-module, round_timer, with load, tick-down and zero-flag outputs; all other logic stays in game_round_ctrl.

Verification
REQ-035 Happy path: rst, then start, then gen_result=5 in LOAD, then submit with guess=5 -> target=5, hit one cycle later, score=1, gen_enable pulses again 1 cycle after CHECK.
REQ-036 Duplicate draw: previous target=9, gen_result=9 in LOAD -> target=10; duplicate wrap: previous target=15, gen_result=15 -> target=0.
REQ-037 Timeout (ROUND_TICKS=4), no submit -> miss exactly 4 cycles after PLAY entry, and lives 3->2; submit and timeout in the same cycle with a correct guess -> hit, lives unchanged.
REQ-038 Three misses from START_LIVES=3 -> lives=0, game_over=1; submit is then ignored; start -> score=0, lives=3, DRAW.
REQ-039 Score saturation: 15 consecutive hits -> score=15, OVER; no wrap to 0.
REQ-040 rst asserted in PLAY with the timer mid-count -> next cycle IDLE with all outputs 0; a later start begins a clean game.
